// File: rtl/ppi_bus_ctrl.sv
// 8255A PPI read/write control: synchronises the CPU strobes, sequences bus cycles,
// owns the control word register and issues one-cycle write/mode/BSR strobes to the ports.
module ppi_bus_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  RESET_CW    = 8'h9B
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       nCs,
  input  logic       nRd,
  input  logic       nWr,
  input  logic [1:0] A,
  input  logic [7:0] D,
  output logic [5:0] control,
  output logic [7:0] controlword,
  output logic [7:0] wr_data,
  output logic       wr_pa,
  output logic       wr_pb,
  output logic       wr_pc,
  output logic       mode_stb,
  output logic       bsr_stb,
  output logic [2:0] bsr_sel,
  output logic       bsr_val,
  output logic       bus_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_COMMIT,
    S_ERROR
  } state_e;

  state_e state_q, state_d;

  // NOTE: reset asserts asynchronously but releases through two flops, so no state
  // flop sees the release edge inside its recovery window.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  logic [SYNC_STAGES-1:0]       ncs_sync_q, nrd_sync_q, nwr_sync_q;
  logic [SYNC_STAGES-1:0][1:0]  a_sync_q;
  logic [SYNC_STAGES-1:0][7:0]  d_pipe_q;

  // D is not synchronised, only delayed by the same depth so it lines up with the
  // synchronised nWr; the bus timing rule keeps it stable across that window.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      ncs_sync_q <= '1;
      nrd_sync_q <= '1;
      nwr_sync_q <= '1;
      a_sync_q   <= '0;
      d_pipe_q   <= '0;
    end else begin
      ncs_sync_q <= {ncs_sync_q[SYNC_STAGES-2:0], nCs};
      nrd_sync_q <= {nrd_sync_q[SYNC_STAGES-2:0], nRd};
      nwr_sync_q <= {nwr_sync_q[SYNC_STAGES-2:0], nWr};
      a_sync_q   <= {a_sync_q[SYNC_STAGES-2:0], A};
      d_pipe_q   <= {d_pipe_q[SYNC_STAGES-2:0], D};
    end
  end

  logic       ncs_s, nrd_s, nwr_s;
  logic [1:0] a_s;
  logic [7:0] d_dly;
  logic       wr_seen, bus_clash, commit, capture;

  assign ncs_s = ncs_sync_q[SYNC_STAGES-1];
  assign nrd_s = nrd_sync_q[SYNC_STAGES-1];
  assign nwr_s = nwr_sync_q[SYNC_STAGES-1];
  assign a_s   = a_sync_q[SYNC_STAGES-1];
  assign d_dly = d_pipe_q[SYNC_STAGES-1];

  // A write is only accepted once nWr has been low in the last two stages, which
  // filters single-clock glitches and guarantees at least one data capture.
  assign wr_seen   = !nwr_s && !nwr_sync_q[SYNC_STAGES-2];
  assign bus_clash = !ncs_s && !nrd_s && !nwr_s;

  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!ncs_s && wr_seen && nrd_s)           state_d = S_WRITE;
        else if (!ncs_s && !nrd_s && nwr_s)       state_d = S_READ;
      end
      S_WRITE:  if (nwr_s || ncs_s)               state_d = S_COMMIT;
      S_READ:   if (nrd_s || ncs_s)               state_d = S_IDLE;
      S_COMMIT:                                   state_d = S_IDLE;
      S_ERROR:  if (nrd_s && nwr_s)               state_d = S_IDLE;
      default:                                    state_d = S_IDLE;
    endcase
    if (bus_clash) state_d = S_ERROR;
  end

  assign commit  = (state_q == S_WRITE) && (state_d == S_COMMIT);
  assign capture = (state_d == S_WRITE);

  logic [7:0] controlword_q, wr_data_q;
  logic [1:0] a_lat_q;
  logic       wr_pa_q, wr_pb_q, wr_pc_q, mode_stb_q, bsr_stb_q;
  logic [2:0] bsr_sel_q;
  logic       bsr_val_q, bus_err_q;

  // Strobes and their qualifiers are loaded on the edge entering COMMIT so that
  // they are all valid together for exactly the COMMIT cycle.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q       <= S_IDLE;
      controlword_q <= RESET_CW;
      wr_data_q     <= '0;
      a_lat_q       <= '0;
      wr_pa_q       <= 1'b0;
      wr_pb_q       <= 1'b0;
      wr_pc_q       <= 1'b0;
      mode_stb_q    <= 1'b0;
      bsr_stb_q     <= 1'b0;
      bsr_sel_q     <= '0;
      bsr_val_q     <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        wr_data_q <= d_dly;
        a_lat_q   <= a_s;
      end
      wr_pa_q    <= commit && (a_lat_q == 2'b00);
      wr_pb_q    <= commit && (a_lat_q == 2'b01);
      wr_pc_q    <= commit && (a_lat_q == 2'b10);
      mode_stb_q <= commit && (a_lat_q == 2'b11) &&  wr_data_q[7];
      bsr_stb_q  <= commit && (a_lat_q == 2'b11) && !wr_data_q[7];
      if (commit && (a_lat_q == 2'b11)) begin
        if (wr_data_q[7]) begin
          controlword_q <= wr_data_q;
        end else begin
          bsr_sel_q <= wr_data_q[3:1];
          bsr_val_q <= wr_data_q[0];
        end
      end
      if (bus_clash) bus_err_q <= 1'b1;
    end
  end

  assign control     = {ncs_s, nrd_s, nwr_s, ~rst_n_int, a_s};
  assign controlword = controlword_q;
  assign wr_data     = wr_data_q;
  assign wr_pa       = wr_pa_q;
  assign wr_pb       = wr_pb_q;
  assign wr_pc       = wr_pc_q;
  assign mode_stb    = mode_stb_q;
  assign bsr_stb     = bsr_stb_q;
  assign bsr_sel     = bsr_sel_q;
  assign bsr_val     = bsr_val_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_ppi_bus_ctrl.sv
// Scoreboard bench for ppi_bus_ctrl: the driver queues the expected strobe for each write,
// a negedge monitor pops and compares whenever any strobe is presented.
module tb_ppi_bus_ctrl;

  localparam int N = 2;

  logic       clk = 1'b0;
  logic       n_reset, n_cs, n_rd, n_wr;
  logic [1:0] a_pin;
  logic [7:0] d_pin;
  logic [5:0] control;
  logic [7:0] controlword, wr_data;
  logic       wr_pa, wr_pb, wr_pc, mode_stb, bsr_stb;
  logic [2:0] bsr_sel;
  logic       bsr_val, bus_err;

  always #5 clk = ~clk;

  ppi_bus_ctrl #(.SYNC_STAGES(N), .RESET_CW(8'h9B)) dut (
    .clk        (clk),
    .nReset     (n_reset),
    .nCs        (n_cs),
    .nRd        (n_rd),
    .nWr        (n_wr),
    .A          (a_pin),
    .D          (d_pin),
    .control    (control),
    .controlword(controlword),
    .wr_data    (wr_data),
    .wr_pa      (wr_pa),
    .wr_pb      (wr_pb),
    .wr_pc      (wr_pc),
    .mode_stb   (mode_stb),
    .bsr_stb    (bsr_stb),
    .bsr_sel    (bsr_sel),
    .bsr_val    (bsr_val),
    .bus_err    (bus_err)
  );

  typedef struct {
    logic [4:0] stb;   // {wr_pa, wr_pb, wr_pc, mode_stb, bsr_stb}
    logic [7:0] data;
    logic [7:0] cw;
    logic [2:0] sel;
    logic       val;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int strobes_seen = 0;

  logic [7:0] cw_m  = 8'h9B;
  logic [2:0] sel_m = 3'd0;
  logic       val_m = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin : monitor
    logic [4:0] stb;
    stb = {wr_pa, wr_pb, wr_pc, mode_stb, bsr_stb};
    if (stb != 5'b0) begin
      strobes_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {27'b0, stb}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_kind",  {27'b0, stb}, {27'b0, mon_e.stb});
        check("strobe_cycle", cyc, mon_e.cyc);
        check("wr_data",      {24'b0, wr_data}, {24'b0, mon_e.data});
        check("controlword",  {24'b0, controlword}, {24'b0, mon_e.cw});
        if (mon_e.stb == 5'b00001) begin
          check("bsr_sel", {29'b0, bsr_sel}, {29'b0, mon_e.sel});
          check("bsr_val", {31'b0, bsr_val}, {31'b0, mon_e.val});
        end
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One CPU write with nWr low for len clocks; the expected strobe is queued at the
  // raw nWr rising edge with its due cycle.
  task automatic do_write(input logic [1:0] a, input logic [7:0] d, input int len);
    exp_t e;
    @(negedge clk);
    a_pin = a; d_pin = d; n_cs = 1'b0; n_wr = 1'b0;
    repeat (len) @(negedge clk);
    n_wr = 1'b1; n_cs = 1'b1;
    case (a)
      2'b00: e.stb = 5'b10000;
      2'b01: e.stb = 5'b01000;
      2'b10: e.stb = 5'b00100;
      default: begin
        if (d[7]) begin
          e.stb = 5'b00010;
          cw_m  = d;
        end else begin
          e.stb = 5'b00001;
          sel_m = d[3:1];
          val_m = d[0];
        end
      end
    endcase
    e.data = d; e.cw = cw_m; e.sel = sel_m; e.val = val_m;
    e.cyc  = cyc + N + 1;
    exp_q.push_back(e);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int seen;
    n_reset = 1'b0; n_cs = 1'b1; n_rd = 1'b1; n_wr = 1'b1;
    a_pin = 2'b00; d_pin = 8'h00;

    wait_clks(2);
    check("rst_control",     {26'b0, control}, 32'h3C);
    check("rst_controlword", {24'b0, controlword}, 32'h9B);
    check("rst_wr_data",     {24'b0, wr_data}, 32'h00);
    check("rst_bus_err",     {31'b0, bus_err}, 32'd0);
    check("rst_bsr",         {28'b0, bsr_sel, bsr_val}, 32'd0);
    n_reset = 1'b1;
    wait_clks(5);
    check("idle_control", {26'b0, control}, 32'h38);

    // control latency on A: visible after N clocks, not before
    a_pin = 2'b11;
    wait_clks(N - 1);
    check("ctl_a_early", {26'b0, control}, 32'h38);
    wait_clks(1);
    check("ctl_a_synced", {26'b0, control}, 32'h3B);
    a_pin = 2'b00;
    wait_clks(3);

    // mode word
    do_write(2'b11, 8'h80, 4);
    wait_clks(6);
    check("mode_cw", {24'b0, controlword}, 32'h80);

    // BSR: set PC7
    do_write(2'b11, 8'h0F, 4);
    wait_clks(6);
    check("bsr_sel_hold", {29'b0, bsr_sel}, 32'd7);
    check("bsr_val_hold", {31'b0, bsr_val}, 32'd1);
    check("bsr_cw_kept",  {24'b0, controlword}, 32'h80);

    // port writes
    do_write(2'b00, 8'hA5, 4); wait_clks(6);
    do_write(2'b01, 8'hA5, 4); wait_clks(6);
    do_write(2'b10, 8'hA5, 4); wait_clks(6);
    check("port_wr_data", {24'b0, wr_data}, 32'hA5);

    // reset in the middle of a write: aborted, no strobe
    seen = strobes_seen;
    @(negedge clk);
    a_pin = 2'b00; d_pin = 8'h55; n_cs = 1'b0; n_wr = 1'b0;
    wait_clks(4);
    n_reset = 1'b0;
    #1;
    check("midrst_control", {26'b0, control}, 32'h3C);
    check("midrst_cw",      {24'b0, controlword}, 32'h9B);
    n_wr = 1'b1; n_cs = 1'b1;
    cw_m = 8'h9B; sel_m = 3'd0; val_m = 1'b0;
    wait_clks(2);
    n_reset = 1'b1;
    wait_clks(8);
    check("midrst_no_strobe", strobes_seen, seen);
    check("midrst_wr_data",   {24'b0, wr_data}, 32'h00);

    // plain read: no strobe, no error
    @(negedge clk);
    n_cs = 1'b0; n_rd = 1'b0;
    wait_clks(3);
    n_cs = 1'b1; n_rd = 1'b1;
    wait_clks(6);
    check("read_no_err",    {31'b0, bus_err}, 32'd0);
    check("read_no_strobe", strobes_seen, seen);

    // illegal cycle: nRd and nWr low together
    @(negedge clk);
    a_pin = 2'b00; d_pin = 8'h77;
    n_cs = 1'b0; n_rd = 1'b0; n_wr = 1'b0;
    wait_clks(3);
    n_cs = 1'b1; n_rd = 1'b1; n_wr = 1'b1;
    wait_clks(N + 3);
    check("err_set", {31'b0, bus_err}, 32'd1);
    wait_clks(10);
    check("err_sticky",    {31'b0, bus_err}, 32'd1);
    check("err_no_strobe", strobes_seen, seen);

    // recovery after error
    do_write(2'b10, 8'h5A, 4);
    wait_clks(6);

    // one-clock glitch on nWr is dropped
    seen = strobes_seen;
    @(negedge clk);
    a_pin = 2'b00; d_pin = 8'hEE; n_cs = 1'b0; n_wr = 1'b0;
    @(negedge clk);
    n_cs = 1'b1; n_wr = 1'b1;
    wait_clks(8);
    check("glitch_no_strobe", strobes_seen, seen);
    check("glitch_wr_data",   {24'b0, wr_data}, 32'h5A);

    // back-to-back writes, one clock apart
    do_write(2'b00, 8'h3C, 4);
    do_write(2'b01, 8'hC3, 4);
    wait_clks(8);
    check("b2b_two_strobes", strobes_seen, seen + 2);

    check("queue_drained", exp_q.size(), 0);

    // only reset clears bus_err
    n_reset = 1'b0;
    #1;
    check("err_cleared_by_reset", {31'b0, bus_err}, 32'd0);
    wait_clks(2);
    n_reset = 1'b1;
    wait_clks(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
